// File: rtl/mem_pkg.sv
// Shared encodings for the two-port Wishbone arbiter.
// Holds FSM states, the word width and the port-select code.
package mem_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with its last-grant register.
// Last-grant resets to port B so port A wins the first contention.
import mem_pkg::*;

module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_valid,
    output logic gnt_port
);

    port_t last_q;
    port_t pick;

    always_comb begin
        pick = PORT_A;
        if (req_a && req_b) begin
            pick = (last_q == PORT_B) ? PORT_A : PORT_B;
        end else if (req_b) begin
            pick = PORT_B;
        end
    end

    assign gnt_valid = en && (req_a || req_b);
    assign gnt_port  = logic'(pick);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= PORT_B;
        end else if (gnt_valid) begin
            last_q <= pick;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one Wishbone
// classic master with retry, timeout and error reporting.
import mem_pkg::*;

module wb_port_arbiter #(
    parameter int CACHE_WIDTH = 128,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic [29:0]              a_addr,
    output logic                     a_ack,
    output logic                     a_err,
    output logic [31:0]              a_data,
    input  logic                     b_req,
    input  logic [29:0]              b_addr,
    input  logic                     b_we,
    input  logic [31:0]              b_wdata,
    input  logic [3:0]               b_be,
    output logic                     b_ack,
    output logic                     b_err,
    output logic [31:0]              b_rdata,
    output logic [31:0]              wb_adr_o,
    output logic [CACHE_WIDTH-1:0]   wb_dat_o,
    output logic                     wb_we_o,
    output logic [CACHE_WIDTH/8-1:0] wb_sel_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic [CACHE_WIDTH-1:0]   wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     wb_rty_i
);

    localparam int LANES = CACHE_WIDTH / WORD_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW    = CACHE_WIDTH / 8;
    localparam int RW    = $clog2(MAX_RETRY + 2);
    localparam int TW    = $clog2(TIMEOUT + 2);

    arb_state_t    state;
    port_t         cur_port;
    logic [LW-1:0] lane_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] tmo_q;

    logic gnt_valid;
    logic gnt_port;
    port_t gnt_sel;

    // A request is still held during its own ack cycle; it is
    // the completed one, so it must not be granted again.
    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_IDLE),
        .req_a     (a_req && !a_ack),
        .req_b     (b_req && !b_ack),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    assign gnt_sel = port_t'(gnt_port);

    logic [29:0]            g_addr;
    logic                   g_we;
    logic [LW-1:0]          g_lane;
    logic [3:0]             g_be;
    logic [SW-1:0]          g_sel;
    logic [CACHE_WIDTH-1:0] g_dat;

    assign g_addr = (gnt_sel == PORT_B) ? b_addr : a_addr;
    assign g_we   = (gnt_sel == PORT_B) && b_we;
    assign g_lane = (LANES > 1) ? g_addr[LW-1:0] : '0;
    assign g_be   = g_we ? b_be : 4'hF;
    assign g_sel  = SW'(g_be) << (4 * g_lane);
    assign g_dat  = g_we ? {LANES{b_wdata}} : '0;

    logic [WORD_WIDTH-1:0] rd_word;
    logic rty_left;
    logic tmo_hit;
    logic bus_fail;
    logic bus_retry;
    logic bus_done;

    assign rd_word   = WORD_WIDTH'(wb_dat_i >> (WORD_WIDTH * lane_q));
    assign rty_left  = retry_q != RW'(MAX_RETRY);
    assign tmo_hit   = tmo_q == TW'(TIMEOUT - 1);
    assign bus_fail  = !wb_ack_i &&
                       (wb_err_i ||
                        (wb_rty_i && !rty_left) ||
                        (!wb_rty_i && tmo_hit));
    assign bus_retry = !wb_ack_i && !wb_err_i &&
                       wb_rty_i && rty_left;
    assign bus_done  = wb_ack_i || bus_fail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cur_port <= PORT_A;
            lane_q   <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_adr_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            a_ack    <= 1'b0;
            a_err    <= 1'b0;
            a_data   <= '0;
            b_ack    <= 1'b0;
            b_err    <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_ack   <= 1'b0;
            a_err   <= 1'b0;
            a_data  <= '0;
            b_ack   <= 1'b0;
            b_err   <= 1'b0;
            b_rdata <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state    <= ST_BUS;
                        cur_port <= gnt_sel;
                        lane_q   <= g_lane;
                        retry_q  <= '0;
                        tmo_q    <= '0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= {g_addr, 2'b00};
                        wb_we_o  <= g_we;
                        wb_sel_o <= g_sel;
                        wb_dat_o <= g_dat;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        state    <= ST_IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= '0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        wb_dat_o <= '0;
                        if (cur_port == PORT_A) begin
                            a_ack  <= 1'b1;
                            a_err  <= bus_fail;
                            a_data <= wb_ack_i ? rd_word : '0;
                        end else begin
                            b_ack   <= 1'b1;
                            b_err   <= bus_fail;
                            b_rdata <= wb_ack_i ? rd_word : '0;
                        end
                    end else if (bus_retry) begin
                        state    <= ST_GAP;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        retry_q  <= retry_q + 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state    <= ST_BUS;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    tmo_q    <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised bench for wb_port_arbiter with a transaction-level
// reference model of arbitration, retry, timeout and completion.
module tb_wb_port_arbiter;

    localparam int TMO  = 255;
    localparam int MAXR = 3;
    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_RTY = 2;
    localparam int K_SIL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_req;
    logic [29:0]  a_addr;
    logic         a_ack, a_err;
    logic [31:0]  a_data;
    logic         b_req;
    logic [29:0]  b_addr;
    logic         b_we;
    logic [31:0]  b_wdata;
    logic [3:0]   b_be;
    logic         b_ack, b_err;
    logic [31:0]  b_rdata;
    logic [31:0]  wb_adr_o;
    logic [127:0] wb_dat_o;
    logic         wb_we_o;
    logic [15:0]  wb_sel_o;
    logic         wb_stb_o, wb_cyc_o;
    logic [127:0] wb_dat_i;
    logic         wb_ack_i, wb_err_i, wb_rty_i;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_ack    (a_ack),
        .a_err    (a_err),
        .a_data   (a_data),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_we     (b_we),
        .b_wdata  (b_wdata),
        .b_be     (b_be),
        .b_ack    (b_ack),
        .b_err    (b_err),
        .b_rdata  (b_rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    typedef enum int {
        M_IDLE, M_BUS, M_GAP, M_REISSUE, M_DONE
    } mphase_t;

    int n_checks = 0;
    int n_fail   = 0;

    mphase_t      ph;
    bit           last_b;
    bit           cur_b;
    logic [29:0]  cur_addr;
    bit           cur_we;
    logic [31:0]  cur_wd;
    logic [3:0]   cur_be;
    int           rty_used, issue_cyc, sl_delay, sl_kind;
    bit           exp_err;
    logic [31:0]  exp_data;
    bit           mask_a, mask_b, cool_a, cool_b;
    int           req_rate;
    int           force_kind;
    int           force_delay;
    bit           fixed_dat_en;
    logic [127:0] fixed_dat;

    task automatic check(string tag, logic [127:0] got,
                         logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [15:0] f_sel(logic [29:0] addr,
                                          bit we,
                                          logic [3:0] be);
        int lane;
        logic [15:0] s;
        lane = int'(addr % 4);
        s = {12'h000, (we ? be : 4'hF)};
        return s << (4 * lane);
    endfunction

    task automatic check_fields();
        check("adr", wb_adr_o, {cur_addr, 2'b00});
        check("we", wb_we_o, cur_we);
        check("sel", wb_sel_o, f_sel(cur_addr, cur_we, cur_be));
        check("dat", wb_dat_o,
              cur_we ? {4{cur_wd}} : 128'h0);
    endtask

    task automatic start_issue();
        int r;
        issue_cyc = 0;
        r = $urandom_range(0, 99);
        if (force_kind >= 0) sl_kind = force_kind;
        else if (r < 60) sl_kind = K_ACK;
        else if (r < 75) sl_kind = K_ERR;
        else sl_kind = K_RTY;
        sl_delay = (force_delay >= 0) ? force_delay
                                      : $urandom_range(0, 3);
        if (sl_kind == K_SIL) sl_delay = 1000000;
    endtask

    task automatic new_a();
        a_req  = 1'b1;
        a_addr = 30'($urandom);
    endtask

    task automatic new_b();
        b_req   = 1'b1;
        b_addr  = 30'($urandom);
        b_we    = 1'($urandom);
        b_wdata = $urandom;
        b_be    = 4'($urandom_range(1, 15));
    endtask

    task automatic step();
        bit ea, eb, ga, gb;
        logic [127:0] t;
        @(negedge clk);
        ea = (ph == M_DONE) && !cur_b;
        eb = (ph == M_DONE) && cur_b;
        check("a_ack", a_ack, ea);
        check("b_ack", b_ack, eb);
        if (ea) begin
            check("a_err", a_err, exp_err);
            check("a_data", a_data, exp_data);
        end
        if (eb) begin
            check("b_err", b_err, exp_err);
            check("b_rdata", b_rdata, exp_data);
        end
        case (ph)
            M_DONE: begin
                check("cyc_drop", wb_cyc_o, 1'b0);
                ph = M_IDLE;
            end
            M_GAP: begin
                check("gap_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
                ph = M_REISSUE;
            end
            M_REISSUE: begin
                check("reissue", {wb_cyc_o, wb_stb_o}, 2'b11);
                check_fields();
                ph = M_BUS;
                start_issue();
            end
            M_BUS: begin
                check("bus_cyc", {wb_cyc_o, wb_stb_o}, 2'b11);
            end
            default: begin
                ga = a_req && !mask_a;
                gb = b_req && !mask_b;
                check("grant", wb_cyc_o, ga || gb);
                if (ga || gb) begin
                    cur_b  = gb && (!ga || !last_b);
                    last_b = cur_b;
                    if (cur_b) begin
                        cur_addr = b_addr;
                        cur_we   = b_we;
                        cur_wd   = b_wdata;
                        cur_be   = b_be;
                    end else begin
                        cur_addr = a_addr;
                        cur_we   = 1'b0;
                        cur_wd   = '0;
                        cur_be   = 4'hF;
                    end
                    check("stb", wb_stb_o, 1'b1);
                    check_fields();
                    rty_used = 0;
                    ph = M_BUS;
                    start_issue();
                end
            end
        endcase
        mask_a = ea;
        mask_b = eb;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = fixed_dat_en ? fixed_dat
                 : {$urandom, $urandom, $urandom, $urandom};
        if (ph == M_BUS) begin
            issue_cyc++;
            if (sl_delay > 0) begin
                sl_delay--;
                if (issue_cyc == TMO) begin
                    exp_err  = 1'b1;
                    exp_data = '0;
                    ph = M_DONE;
                end
            end else if (sl_kind == K_ACK) begin
                wb_ack_i = 1'b1;
                wb_err_i = 1'($urandom);
                wb_rty_i = 1'($urandom);
                t = wb_dat_i >> (32 * int'(cur_addr % 4));
                exp_err  = 1'b0;
                exp_data = t[31:0];
                ph = M_DONE;
            end else if (sl_kind == K_ERR) begin
                wb_err_i = 1'b1;
                wb_rty_i = 1'($urandom);
                exp_err  = 1'b1;
                exp_data = '0;
                ph = M_DONE;
            end else begin
                wb_rty_i = 1'b1;
                if (rty_used == MAXR) begin
                    exp_err  = 1'b1;
                    exp_data = '0;
                    ph = M_DONE;
                end else begin
                    rty_used++;
                    ph = M_GAP;
                end
            end
        end
        if (ea) cool_a = 1'b1;
        else if (cool_a) begin
            cool_a = 1'b0;
            if ($urandom_range(0, 99) < req_rate) new_a();
            else a_req = 1'b0;
        end else if (!a_req && $urandom_range(0, 99) < req_rate)
            new_a();
        if (eb) cool_b = 1'b1;
        else if (cool_b) begin
            cool_b = 1'b0;
            if ($urandom_range(0, 99) < req_rate) new_b();
            else b_req = 1'b0;
        end else if (!b_req && $urandom_range(0, 99) < req_rate)
            new_b();
    endtask

    task automatic do_reset(int n);
        rst = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 128'h0);
        check("rst_sel_we", {wb_sel_o, wb_we_o}, 17'h0);
        check("rst_acks", {a_ack, a_err, b_ack, b_err}, 4'h0);
        check("rst_rdata", {a_data, b_rdata}, 64'h0);
        rst = 1'b1;
        ph = M_IDLE;
        last_b = 1'b1;
        mask_a = 1'b0;
        mask_b = 1'b0;
        cool_a = 1'b0;
        cool_b = 1'b0;
    endtask

    task automatic drain(int max);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (ph == M_IDLE && !a_req && !b_req) begin
                idle = 1'b1;
                break;
            end
        end
        check("drain", idle, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        a_req = 1'b0;
        a_addr = '0;
        b_req = 1'b0;
        b_addr = '0;
        b_we = 1'b0;
        b_wdata = '0;
        b_be = '0;
        wb_dat_i = '0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        req_rate = 0;
        force_kind = K_ACK;
        force_delay = 0;
        fixed_dat_en = 1'b0;
        fixed_dat = '0;
        @(negedge clk);
        do_reset(3);

        fixed_dat_en = 1'b1;
        fixed_dat = 128'h11111111_22222222_DEADBEEF_33333333;
        a_req = 1'b1;
        a_addr = 30'd1;
        drain(10);
        fixed_dat_en = 1'b0;

        b_req = 1'b1;
        b_addr = 30'd3;
        b_we = 1'b1;
        b_wdata = 32'h12345678;
        b_be = 4'b0011;
        drain(10);

        force_kind = K_RTY;
        a_req = 1'b1;
        a_addr = 30'h2A5;
        drain(30);

        force_kind = K_SIL;
        b_req = 1'b1;
        b_addr = 30'h7;
        b_we = 1'b0;
        drain(300);

        b_req = 1'b1;
        b_addr = 30'h9;
        repeat (4) step();
        do_reset(1);
        force_kind = K_ACK;
        repeat (3) step();
        a_req = 1'b1;
        a_addr = 30'h12;
        drain(10);

        @(negedge clk);
        do_reset(1);
        force_kind = -1;
        force_delay = -1;
        req_rate = 100;
        new_a();
        new_b();
        repeat (80) step();

        req_rate = 40;
        repeat (1500) step();
        req_rate = 0;
        drain(400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
